// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared constants, FSM state type and the "first set bit"
//               helper for the scan select generator.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int NUM_POS = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] first_set(input logic [NUM_POS-1:0] mask);
        first_set = '0;
        for (int i = NUM_POS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_set = SEL_W'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_next_idx.sv
`default_nettype none
// ============================================================================
// Module      : scan_next_idx
// Description : Rotating priority encoder. Finds the first set mask bit
//               after cur (cur+1, cur+2, ... wrapping, ending at cur itself).
//               wrap flags that the result is not above cur.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_next_idx
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]   cur,
    input  logic [NUM_POS-1:0] mask,
    output logic [SEL_W-1:0]   nxt,
    output logic               wrap
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    // Walk positions cur+1 .. cur+8; the 3-bit sum wraps modulo 8 so the
    // final candidate is cur itself (single-bit mask case).
    always_comb begin
        nxt     = cur;
        w_found = 1'b0;
        w_idx   = cur;
        for (int k = 1; k <= NUM_POS; k++) begin
            w_idx = cur + SEL_W'(k);
            if (!w_found && mask[w_idx]) begin
                nxt     = w_idx;
                w_found = 1'b1;
            end
        end
        wrap = (nxt <= cur);
    end

endmodule
`default_nettype wire

// File: rtl/scan_sel_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_sel_gen
// Description : Select/enable sequencer for a 3-to-8 decoder. Visits the
//               enabled positions in order, holding each for SHOW_CYC cycles
//               followed by a BLANK_CYC blanking gap, and pulses frame when
//               the scan wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int SHOW_CYC  = 4,
    parameter int BLANK_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [NUM_POS-1:0] mask,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               frame
);

    localparam logic [CNT_W-1:0] c_show_last  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] c_blank_last = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam bit               c_has_blank  = (BLANK_CYC > 0);

    scan_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic             r_en;
    logic             r_frame;

    scan_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_en_nxt;
    logic             w_frame_nxt;

    logic [SEL_W-1:0] w_adv_idx;
    logic             w_adv_wrap;
    logic             w_abort;

    scan_next_idx u_next_idx (
        .cur  (r_sel),
        .mask (mask),
        .nxt  (w_adv_idx),
        .wrap (w_adv_wrap)
    );

    assign w_abort = !run || (mask == '0);

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_sel_nxt   = r_sel;
        w_en_nxt    = r_en;
        w_frame_nxt = 1'b0;

        if (w_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_en_nxt    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Entry from idle never counts as a wrap.
                    w_state_nxt = SHOW;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = first_set(mask);
                    w_en_nxt    = 1'b1;
                end
                SHOW: begin
                    w_en_nxt = 1'b1;
                    if (r_cnt == c_show_last) begin
                        w_cnt_nxt = '0;
                        if (c_has_blank) begin
                            w_state_nxt = BLANK;
                            w_en_nxt    = 1'b0;
                        end else begin
                            // No gap: advance directly while staying in SHOW.
                            w_sel_nxt   = w_adv_idx;
                            w_frame_nxt = w_adv_wrap;
                        end
                    end
                end
                BLANK: begin
                    w_en_nxt = 1'b0;
                    if (r_cnt == c_blank_last) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = w_adv_idx;
                        w_en_nxt    = 1'b1;
                        w_frame_nxt = w_adv_wrap;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign sel   = r_sel;
    assign en    = r_en;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_scan_sel_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_sel_gen
// Description : Self-checking bench for scan_sel_gen. Runs a default build
//               (4/1 dwell) and a no-gap build (4/0) side by side against a
//               digit-period reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] mask;

    logic [2:0] sel_a, sel_b;
    logic       en_a, en_b, frame_a, frame_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: index 0 = default build, 1 = no-gap build.
    int         m_act [2];
    int         m_pos [2];
    logic [2:0] m_sel [2];
    logic       m_en  [2];
    logic       m_frame [2];
    int         showc  [2] = '{4, 4};
    int         blankc [2] = '{1, 0};

    always #5 clk = ~clk;

    scan_sel_gen #(.SHOW_CYC(4), .BLANK_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
        .sel(sel_a), .en(en_a), .frame(frame_a)
    );

    scan_sel_gen #(.SHOW_CYC(4), .BLANK_CYC(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .run(run), .mask(mask),
        .sel(sel_b), .en(en_b), .frame(frame_b)
    );

    function automatic logic [2:0] ref_first(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [2:0] ref_next(input logic [2:0] cur, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            int j;
            j = (int'(cur) + k) % 8;
            if (m[j]) return 3'(j);
        end
        return cur;
    endfunction

    // One clock edge: advance both models from the inputs seen at the edge,
    // then settle so outputs are sampled away from the edge.
    task automatic tick();
        logic [2:0] nx;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 0; m_pos[d] = 0; m_sel[d] = 3'd0; m_en[d] = 1'b0; m_frame[d] = 1'b0;
            end else if (!run || mask == 8'h00) begin
                m_act[d] = 0; m_en[d] = 1'b0; m_frame[d] = 1'b0;
            end else if (m_act[d] == 0) begin
                m_act[d] = 1; m_pos[d] = 0; m_sel[d] = ref_first(mask);
                m_en[d] = 1'b1; m_frame[d] = 1'b0;
            end else begin
                m_pos[d]   = m_pos[d] + 1;
                m_frame[d] = 1'b0;
                if (m_pos[d] == showc[d] + blankc[d]) begin
                    m_pos[d]   = 0;
                    nx         = ref_next(m_sel[d], mask);
                    m_frame[d] = (nx <= m_sel[d]);
                    m_sel[d]   = nx;
                end
                m_en[d] = (m_pos[d] < showc[d]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mask = 8'h00;
        tick();
        tick();
        checks++;
        if ({sel_a, en_a, frame_a} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_a: got sel=%0d en=%0b frame=%0b, want 0/0/0", sel_a, en_a, frame_a);
        end
        checks++;
        if ({sel_b, en_b, frame_b} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_b: got sel=%0d en=%0b frame=%0b, want 0/0/0", sel_b, en_b, frame_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_mask();
        int last = -1;
        int npulse = 0;
        run = 1'b1; mask = 8'hFF;
        tick();
        checks++;
        if (sel_a !== 3'd0 || en_a !== 1'b1) begin
            errors++;
            $display("FAIL start_full: got sel=%0d en=%0b, want sel=0 en=1", sel_a, en_a);
        end
        repeat (90) begin
            tick();
            checks++;
            if ({sel_a, en_a, frame_a} !== {m_sel[0], m_en[0], m_frame[0]}) begin
                errors++;
                $display("FAIL full_mask: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_a, en_a, frame_a, m_sel[0], m_en[0], m_frame[0]);
            end
            if (frame_a === 1'b1) begin
                npulse++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 40) begin
                        errors++;
                        $display("FAIL frame_period_full: got %0d cycles, want 40", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (npulse < 2) begin
            errors++;
            $display("FAIL frame_count_full: got %0d pulses, want >=2", npulse);
        end
    endtask

    task automatic test_sparse_mask();
        mask = 8'b1010_0100;
        repeat (60) begin
            tick();
            checks++;
            if ({sel_a, en_a, frame_a} !== {m_sel[0], m_en[0], m_frame[0]}) begin
                errors++;
                $display("FAIL sparse_mask: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_a, en_a, frame_a, m_sel[0], m_en[0], m_frame[0]);
            end
            if (frame_a === 1'b1) begin
                checks++;
                if (sel_a !== 3'd2) begin
                    errors++;
                    $display("FAIL sparse_wrap_sel: got sel=%0d at frame, want 2", sel_a);
                end
            end
        end
    endtask

    task automatic test_single_bit();
        int last = -1;
        mask = 8'b0001_0000;
        repeat (30) begin
            tick();
            checks++;
            if ({sel_a, en_a, frame_a} !== {m_sel[0], m_en[0], m_frame[0]}) begin
                errors++;
                $display("FAIL single_bit: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_a, en_a, frame_a, m_sel[0], m_en[0], m_frame[0]);
            end
            if (frame_a === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 5) begin
                        errors++;
                        $display("FAIL frame_period_single: got %0d cycles, want 5", cyc - last);
                    end
                end
                last = cyc;
            end
        end
    endtask

    task automatic test_run_abort();
        bit found = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        run = 1'b1; mask = 8'hFF;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            checks++;
            if ({sel_a, en_a, frame_a} !== {m_sel[0], m_en[0], m_frame[0]}) begin
                errors++;
                $display("FAIL run_abort_walk: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_a, en_a, frame_a, m_sel[0], m_en[0], m_frame[0]);
            end
            if (m_act[0] != 0 && m_sel[0] == 3'd3 && m_pos[0] == 1) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL run_abort_timeout: sel=3 second SHOW cycle not reached");
            return;
        end
        run = 1'b0;
        tick();
        checks++;
        if ({sel_a, en_a, frame_a} !== 5'b011_0_0) begin
            errors++;
            $display("FAIL run_abort_hold: got sel=%0d en=%0b frame=%0b, want sel=3 en=0 frame=0",
                     sel_a, en_a, frame_a);
        end
        run = 1'b1;
        tick();
        checks++;
        if ({sel_a, en_a, frame_a} !== 5'b000_1_0) begin
            errors++;
            $display("FAIL run_restart: got sel=%0d en=%0b frame=%0b, want sel=0 en=1 frame=0",
                     sel_a, en_a, frame_a);
        end
    endtask

    task automatic test_mask_abort();
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (m_act[0] != 0 && m_pos[0] == 4) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL mask_abort_timeout: BLANK not reached");
            return;
        end
        mask = 8'h00;
        tick();
        checks++;
        if (en_a !== 1'b0 || frame_a !== 1'b0) begin
            errors++;
            $display("FAIL mask_abort: got en=%0b frame=%0b, want en=0 frame=0", en_a, frame_a);
        end
        tick();
        checks++;
        if (en_a !== 1'b0) begin
            errors++;
            $display("FAIL mask_abort_idle: got en=%0b, want 0", en_a);
        end
        mask = 8'h01;
        tick();
        checks++;
        if ({sel_a, en_a, frame_a} !== 5'b000_1_0) begin
            errors++;
            $display("FAIL mask_restart: got sel=%0d en=%0b frame=%0b, want sel=0 en=1 frame=0",
                     sel_a, en_a, frame_a);
        end
    endtask

    task automatic test_no_gap();
        int npulse = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        run = 1'b1; mask = 8'h81;
        repeat (34) begin
            tick();
            checks++;
            if ({sel_b, en_b, frame_b} !== {m_sel[1], m_en[1], m_frame[1]}) begin
                errors++;
                $display("FAIL no_gap: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_b, en_b, frame_b, m_sel[1], m_en[1], m_frame[1]);
            end
            if (frame_b === 1'b1) npulse++;
        end
        checks++;
        if (npulse < 3) begin
            errors++;
            $display("FAIL no_gap_frames: got %0d pulses, want >=3", npulse);
        end
        // 34 ticks after start lands in the middle of a dwell.
        rst = 1'b1;
        tick();
        checks++;
        if ({sel_b, en_b, frame_b} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_mid_show: got sel=%0d en=%0b frame=%0b, want 0/0/0", sel_b, en_b, frame_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        run = 1'b1; mask = 8'h5A;
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) rst = 1'b1; else rst = 1'b0;
            run = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 7) == 0) mask = 8'h00;
                else mask = 8'($urandom());
            end
            tick();
            checks++;
            if ({sel_a, en_a, frame_a} !== {m_sel[0], m_en[0], m_frame[0]}) begin
                errors++;
                $display("FAIL random_a: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_a, en_a, frame_a, m_sel[0], m_en[0], m_frame[0]);
            end
            checks++;
            if ({sel_b, en_b, frame_b} !== {m_sel[1], m_en[1], m_frame[1]}) begin
                errors++;
                $display("FAIL random_b: got sel=%0d en=%0b frame=%0b, want sel=%0d en=%0b frame=%0b",
                         sel_b, en_b, frame_b, m_sel[1], m_en[1], m_frame[1]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_pos[d] = 0; m_sel[d] = 3'd0; m_en[d] = 1'b0; m_frame[d] = 1'b0;
        end
        rst = 1'b1; run = 1'b0; mask = 8'h00;
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_single_bit();
        test_run_abort();
        test_mask_abort();
        test_no_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
Upstream sequencer for the 3-to-8 decoder stage (dec3to8_shift / dec3to8_case). It produces the decoder's 3-bit select and enable: it walks the enabled digit positions in order, holding each for a programmable dwell and then inserting a blanking gap. It also flags the end of each scan frame. The decoder's one-hot output then drives display digit commons or row strobes.

Parameters:
SHOW_CYC, 4, clock cycles en is held high per digit (>=1, < 2**CNT_W)
BLANK_CYC, 1, clock cycles en is held low between digits (>=0, < 2**CNT_W); 0 = no gap
CNT_W, 16, dwell counter width

Ports:
clk    input   1  system clock, all logic on rising edge
rst    input   1  synchronous active-high reset; one clock, reset is synchronous and active-high
run    input   1  1 = scanning enabled; 0 = return to idle
mask   input   8  per-position enable; bit i=1 means position i is visited
sel    output  3  select index to decoder in[2:0], registered
en     output  1  decoder enable, registered
frame  output  1  one-cycle pulse when the scan wraps to a lower or equal index

Behaviour:
- All outputs are registered. rst has priority over every other input.
- Reset values: sel=0, en=0, frame=0, state=IDLE, cnt=0.
- States: IDLE, SHOW, BLANK. cnt is a CNT_W-bit dwell counter, cleared on every state entry.
- nxt(i): first set mask bit scanning i+1, i+2, ... wrapping through 7 to 0 and ending at i. If only bit i is set, nxt(i)=i. Mask is sampled combinationally at the decision cycle.
- first: lowest set mask bit.
- Abort rule: in any state, if run=0 or mask==0, next edge: state=IDLE, en=0, frame=0, sel holds its value.
- IDLE: en=0. If run=1 and mask!=0, next edge: sel=first, en=1, state=SHOW. The sel transition out of IDLE never pulses frame.
- SHOW: en=1, cnt increments each cycle. At cnt==SHOW_CYC-1:
  - if BLANK_CYC>0: state=BLANK, en=0, sel holds.
  - if BLANK_CYC==0: sel=nxt(sel), en stays 1, state stays SHOW.
- BLANK: en=0, cnt increments each cycle. At cnt==BLANK_CYC-1: sel=nxt(sel), en=1, state=SHOW.
- frame=1 for exactly the cycle in which sel first shows an advanced value that is <= the previous value (wrap or single-bit mask). Otherwise frame=0.
- Digit period is SHOW_CYC+BLANK_CYC cycles. Frame period is (number of set mask bits) x that.
- Mask changes mid-dwell do not shorten the current dwell. They affect only the next nxt() evaluation, except that mask==0 aborts.
- Changing sel while en=1 is allowed only when BLANK_CYC==0.
- No combinational path from any input to any output.

Decomposition:
- Shared package scan_pkg: NUM_POS=8, SEL_W=3, state enum {IDLE, SHOW, BLANK}.
- One sub-module: scan_next_idx, a combinational rotating priority encoder (cur[2:0], mask[7:0] -> nxt[2:0], wrap). Instantiate it once.
- Counter, FSM and output registers stay in scan_sel_gen.

Test Plan:
1. Defaults, rst 2 cycles, then run=1, mask=8'hFF -> one edge later sel=0, en=1. en high 4 cycles, low 1. sel steps 0..7 every 5 cycles. frame pulses with sel 7->0, every 40 cycles.
2. mask=8'b1010_0100 -> sel sequence 2,5,7,2,5,7. frame on each 7->2 transition, period 15 cycles.
3. mask=8'b0001_0000 -> sel stays 4, en pattern 1111_0 repeating, frame pulses every 5 cycles as each SHOW re-entry begins.
4. run=0 in the 2nd SHOW cycle at sel=3 -> next edge en=0, IDLE, sel=3 held. run=1 again -> sel=first, en=1, no frame pulse.
5. mask=0 during BLANK -> next edge IDLE, en=0. Then mask=8'h01 -> sel=0, en=1.
6. BLANK_CYC=0 build, mask=8'h81 -> en constantly 1, sel alternates 0,7 every 4 cycles, frame at each 7->0. rst asserted mid-SHOW with run=1 -> next edge sel=0, en=0, frame=0.
